dsi_lane_feeder: RTL and testbench

- Downstream consumer of the 4-byte repacker in the DSI HS data path.
- Pulls 32-bit words (one byte per lane) from the repacker and frames each packet per lane with the HS sync byte and HS trail bytes.
- Presents byte-per-lane data to the lane serializers under a valid/ready handshake.
- One packet per start pulse; signals completion when all active lanes have finished their trail.

---
 rtl/dsi_lane_feeder.sv | 162 ++++++++++++++++
 tb/tb_dsi_lane_feeder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_lane_feeder.sv
// dsi_lane_feeder: frames repacker words into per-lane HS bursts (sync byte, data, trail).
// Defining DSI_LANE_FEEDER_BYTE_CNT_EN adds a saturating per-packet data byte counter output.
module dsi_lane_feeder #(
    parameter int         TRAIL_W   = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         cfg_lanes,
    input  logic [TRAIL_W-1:0] cfg_trail_cycles,
    output logic               busy,
    output logic               done,
    output logic               rep_enable,
    output logic               data_req,
    input  logic [31:0]        rep_data,
    input  logic [3:0]         rep_last_strb,
    input  logic               lane_ready,
    output logic [31:0]        lane_data,
    output logic [3:0]         lane_valid
`ifdef DSI_LANE_FEEDER_BYTE_CNT_EN
    ,
    output logic [15:0]        byte_cnt
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_SYNC, S_DATA, S_TRAIL} state_t;

    state_t             r_state;
    logic               r_prepCnt;
    logic [1:0]         r_lanes;
    logic [TRAIL_W-1:0] r_trail;
    logic [3:0]         r_laneDone;
    logic [3:0]         r_tbit;
    logic [TRAIL_W-1:0] r_cnt [4];
    logic [31:0]        r_laneData;
    logic [3:0]         r_laneValid;
    logic               r_repEn;
    logic               r_done;
    logic               w_accept;
    logic [3:0]         w_active;

    assign w_accept   = lane_ready | ~|r_laneValid;
    assign w_active   = 4'b1111 >> (2'd3 - r_lanes);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign rep_enable = r_repEn;
    assign lane_data  = r_laneData;
    assign lane_valid = r_laneValid;
    // Lane 0 always carries the packet's final byte, so its strobe ends the request stream.
    assign data_req   = (r_state == S_DATA) & w_accept & ~rep_last_strb[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_prepCnt   <= 1'b0;
            r_lanes     <= '0;
            r_trail     <= '0;
            r_laneDone  <= '0;
            r_tbit      <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
            r_laneData  <= '0;
            r_laneValid <= '0;
            r_repEn     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lanes    <= cfg_lanes;
                        r_trail    <= (cfg_trail_cycles == '0) ? TRAIL_W'(1) : cfg_trail_cycles;
                        r_repEn    <= 1'b1;
                        r_prepCnt  <= 1'b0;
                        r_laneDone <= '0;
                        r_tbit     <= '0;
                        for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
                        r_state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (r_prepCnt) r_state <= S_SYNC;
                    else           r_prepCnt <= 1'b1;
                end
                S_SYNC: begin
                    if (w_accept) begin
                        for (int i = 0; i < 4; i++)
                            if (w_active[i]) r_laneData[8*i +: 8] <= SYNC_BYTE;
                        r_laneValid <= w_active;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        for (int i = 0; i < 4; i++) begin
                            if (w_active[i]) begin
                                if (!r_laneDone[i]) begin
                                    r_laneData[8*i +: 8] <= rep_data[8*i +: 8];
                                    if (rep_last_strb[i]) begin
                                        r_laneDone[i] <= 1'b1;
                                        r_tbit[i]     <= ~rep_data[8*i+7];
                                        r_cnt[i]      <= r_trail;
                                    end
                                end else if (r_cnt[i] != '0) begin
                                    r_laneData[8*i +: 8] <= {8{r_tbit[i]}};
                                    r_cnt[i]             <= r_cnt[i] - TRAIL_W'(1);
                                end else begin
                                    r_laneValid[i] <= 1'b0;
                                end
                            end
                        end
                        if (rep_last_strb[0]) r_state <= S_TRAIL;
                    end
                end
                S_TRAIL: begin
                    if (~|r_laneValid) begin
                        r_repEn <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        for (int i = 0; i < 4; i++) begin
                            if (w_active[i]) begin
                                if (r_cnt[i] != '0) begin
                                    r_laneData[8*i +: 8] <= {8{r_tbit[i]}};
                                    r_cnt[i]             <= r_cnt[i] - TRAIL_W'(1);
                                end else begin
                                    r_laneValid[i] <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DSI_LANE_FEEDER_BYTE_CNT_EN
    logic [15:0] r_byteCnt;
    logic [2:0]  w_newBytes;
    logic [16:0] w_cntSum;

    always_comb begin
        w_newBytes = '0;
        for (int i = 0; i < 4; i++)
            w_newBytes = w_newBytes + {2'b00, w_active[i] & ~r_laneDone[i]};
        w_cntSum = {1'b0, r_byteCnt} + {14'd0, w_newBytes};
    end

    // Only bytes taken from the repacker count; sync and trail bytes never do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_byteCnt <= '0;
        else if (r_state == S_IDLE && start)
            r_byteCnt <= '0;
        else if (r_state == S_DATA && w_accept)
            r_byteCnt <= w_cntSum[16] ? 16'hFFFF : w_cntSum[15:0];
    end

    assign byte_cnt = r_byteCnt;
`endif

endmodule

// File: tb/tb_dsi_lane_feeder.sv
// tb_dsi_lane_feeder: drives packets from a model repacker and compares each lane's byte
// stream against streams built directly from the framing rules (sync, data, trail).
module tb_dsi_lane_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cfg_lanes;
    logic [3:0]  cfg_trail_cycles;
    logic        busy, done, rep_enable, data_req;
    logic [31:0] rep_data;
    logic [3:0]  rep_last_strb;
    logic        lane_ready;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
`ifdef DSI_LANE_FEEDER_BYTE_CNT_EN
    logic [15:0] byte_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] words [4];
    logic [3:0]  strbs [4];

    always #5 clk = ~clk;

    dsi_lane_feeder dut (
        .clk(clk), .rst(rst), .start(start), .cfg_lanes(cfg_lanes),
        .cfg_trail_cycles(cfg_trail_cycles), .busy(busy), .done(done),
        .rep_enable(rep_enable), .data_req(data_req), .rep_data(rep_data),
        .rep_last_strb(rep_last_strb), .lane_ready(lane_ready),
        .lane_data(lane_data), .lane_valid(lane_valid)
`ifdef DSI_LANE_FEEDER_BYTE_CNT_EN
        , .byte_cnt(byte_cnt)
`endif
    );

    // Random packet: lane 0 ends on the last word, other active lanes end on any word up to it.
    task automatic gen_packet(input logic [1:0] lanes, input int nwords);
        int lw;
        for (int w = 0; w < 4; w++) begin
            words[w] = $urandom;
            strbs[w] = 4'($urandom_range(0, 15));
        end
        for (int w = 0; w < nwords; w++) strbs[w][0] = (w == nwords - 1);
        for (int i = 1; i < 4; i++) begin
            if (i <= int'(lanes)) begin
                lw = $urandom_range(0, nwords - 1);
                for (int w = 0; w <= lw; w++) strbs[w][i] = (w == lw);
            end
        end
    endtask

    task automatic run_packet(input string name, input logic [1:0] lanes, input logic [3:0] trail,
                              input int nwords, input int readyMode, input bit injectStart);
        int         lastWord [4];
        int         len [4];
        logic [7:0] expBytes [4][24];
        logic [3:0] mask;
        logic [7:0] tbyte;
        int         effTrail, k, reqCount, widx, expCnt;
        bit         reqPending, doneSeen, expV;

        effTrail = (trail == 4'd0) ? 1 : int'(trail);
        expCnt   = 0;
        for (int i = 0; i < 4; i++) begin
            mask[i]     = (i <= int'(lanes));
            lastWord[i] = nwords - 1;
            for (int w = nwords - 1; w >= 0; w--) if (strbs[w][i]) lastWord[i] = w;
            len[i] = 2 + lastWord[i] + effTrail;
            expBytes[i][0] = 8'hB8;
            for (int w = 0; w <= lastWord[i]; w++) expBytes[i][1 + w] = words[w][8*i +: 8];
            tbyte = {8{~words[lastWord[i]][8*i+7]}};
            for (int t = 0; t < effTrail; t++) expBytes[i][2 + lastWord[i] + t] = tbyte;
            if (mask[i]) expCnt += lastWord[i] + 1;
        end

        k = 0; reqCount = 0; widx = 0; reqPending = 0; doneSeen = 0;
        @(posedge clk); #1;
        rep_data = words[0]; rep_last_strb = strbs[0]; lane_ready = 1'b1;
        cfg_lanes = lanes; cfg_trail_cycles = trail; start = 1'b1;
        for (int cyc = 0; cyc < 400 && !doneSeen; cyc++) begin
            @(negedge clk);
            if (done) begin
                doneSeen = 1;
                total++;
                if (busy !== 1'b0 || rep_enable !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL %s/idle_at_done got busy=%b en=%b want 0 0", name, busy, rep_enable);
                end
            end else begin
                if (cyc > 0) begin
                    total++;
                    if ({busy, rep_enable} !== 2'b11) begin
                        bad++;
                        $display("[TB] FAIL %s/busy cyc=%0d got=%b want=11", name, cyc, {busy, rep_enable});
                    end
                end
                total++;
                if ((lane_valid & ~mask) !== 4'b0000) begin
                    bad++;
                    $display("[TB] FAIL %s/inactive_valid got=%b want=0000", name, lane_valid & ~mask);
                end
                if (data_req === 1'b1) begin
                    reqCount++;
                    reqPending = 1;
                    total++;
                    if (lane_ready !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL %s/req_without_ready got ready=%b want 1", name, lane_ready);
                    end
                end
                if (lane_ready && lane_valid != 4'b0000) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mask[i]) begin
                            expV = (k < len[i]);
                            total++;
                            if (lane_valid[i] !== expV) begin
                                bad++;
                                $display("[TB] FAIL %s/valid lane%0d xfer%0d got=%b want=%b", name, i, k, lane_valid[i], expV);
                            end else if (expV) begin
                                total++;
                                if (lane_data[8*i +: 8] !== expBytes[i][k]) begin
                                    bad++;
                                    $display("[TB] FAIL %s/byte lane%0d xfer%0d got=%h want=%h", name, i, k, lane_data[8*i +: 8], expBytes[i][k]);
                                end
                            end
                        end
                    end
                    k++;
                end
                @(posedge clk); #1;
                start = 1'b0;
                if (injectStart && cyc == 3) begin
                    start = 1'b1;
                    cfg_lanes = ~lanes;
                    cfg_trail_cycles = trail + 4'd5;
                end
                if (reqPending) begin
                    if (widx < nwords - 1) widx++;
                    reqPending = 0;
                end
                rep_data = words[widx];
                rep_last_strb = strbs[widx];
                case (readyMode)
                    1:       lane_ready = (cyc % 2 == 1);
                    2:       lane_ready = ($urandom_range(0, 3) != 0);
                    default: lane_ready = 1'b1;
                endcase
            end
        end
        start = 1'b0;
        lane_ready = 1'b1;
        total++;
        if (!doneSeen) begin
            bad++;
            $display("[TB] FAIL %s/timeout got no done want done within 400 cycles", name);
        end
        total++;
        if (k !== len[0]) begin
            bad++;
            $display("[TB] FAIL %s/xfer_count got=%0d want=%0d", name, k, len[0]);
        end
        total++;
        if (reqCount !== nwords - 1) begin
            bad++;
            $display("[TB] FAIL %s/req_count got=%0d want=%0d", name, reqCount, nwords - 1);
        end
`ifdef DSI_LANE_FEEDER_BYTE_CNT_EN
        total++;
        if (byte_cnt !== 16'(expCnt)) begin
            bad++;
            $display("[TB] FAIL %s/byte_cnt got=%0d want=%0d", name, byte_cnt, expCnt);
        end
`endif
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s/done_pulse got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({lane_data, lane_valid} !== 36'd0) begin
            bad++;
            $display("[TB] FAIL reset/lanes got=%h want=0", {lane_data, lane_valid});
        end
        total++;
        if ({busy, done, rep_enable, data_req} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset/ctrl got=%b want=0000", {busy, done, rep_enable, data_req});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, lane_valid} !== 6'd0) begin
            bad++;
            $display("[TB] FAIL reset/after_release got=%b want=0", {busy, done, lane_valid});
        end
    endtask

    task automatic test_basic();
        words[0] = 32'h8A7B6C5D; strbs[0] = 4'b0000;
        words[1] = 32'h1E2F90A3; strbs[1] = 4'b1111;
        run_packet("basic", 2'd3, 4'd2, 2, 0, 1'b0);
    endtask

    task automatic test_early_lanes();
        words[0] = 32'hA1B2C3D4; strbs[0] = 4'b1100;
        words[1] = 32'h11223344; strbs[1] = 4'b0011;
        run_packet("early", 2'd3, 4'd1, 2, 0, 1'b0);
    endtask

    task automatic test_trail_polarity();
        words[0] = 32'h00000080; strbs[0] = 4'b0001;
        run_packet("pol80", 2'd0, 4'd3, 1, 0, 1'b0);
        words[0] = 32'h0000007F; strbs[0] = 4'b0001;
        run_packet("pol7F_trail0", 2'd0, 4'd0, 1, 0, 1'b0);
    endtask

    task automatic test_two_lanes();
        gen_packet(2'd1, 3);
        run_packet("two_lanes", 2'd1, 4'd2, 3, 0, 1'b0);
    endtask

    task automatic test_ready_toggle();
        words[0] = 32'h8A7B6C5D; strbs[0] = 4'b0000;
        words[1] = 32'h1E2F90A3; strbs[1] = 4'b1111;
        run_packet("toggle", 2'd3, 4'd2, 2, 1, 1'b1);
    endtask

    task automatic test_mid_reset();
        gen_packet(2'd3, 4);
        @(posedge clk); #1;
        rep_data = words[0]; rep_last_strb = strbs[0]; lane_ready = 1'b1;
        cfg_lanes = 2'd3; cfg_trail_cycles = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || lane_valid !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL midrst/pre got busy=%b valid=%b want 1 1111", busy, lane_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({lane_data, lane_valid, busy, done, rep_enable, data_req} !== 40'd0) begin
            bad++;
            $display("[TB] FAIL midrst/cleared got=%h want=0", {lane_data, lane_valid, busy, done, rep_enable, data_req});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({done, busy, rep_enable} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL midrst/no_done cyc=%0d got=%b want=000", c, {done, busy, rep_enable});
            end
        end
        gen_packet(2'd3, 3);
        run_packet("after_rst", 2'd3, 4'd2, 3, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] lanes;
        int         nwords;
        logic [3:0] trail;
        for (int p = 0; p < 10; p++) begin
            lanes  = 2'($urandom_range(0, 3));
            nwords = $urandom_range(1, 4);
            trail  = 4'($urandom_range(0, 15));
            gen_packet(lanes, nwords);
            run_packet("random", lanes, trail, nwords, 2, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_lanes = '0; cfg_trail_cycles = '0;
        rep_data = '0; rep_last_strb = '0; lane_ready = 1'b1;
        test_reset();
        test_basic();
        test_early_lanes();
        test_trail_polarity();
        test_two_lanes();
        test_ready_toggle();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
